systolic_gemm_scheduler: RTL and testbench
==========================================

# systolic_gemm_scheduler

Breaks one large GEMM command into a sequence of single-tile matmul commands for the systolic-array core, one tile at a time. It sits between the host command interface and the core's `cmd_matmul`/`resp_matmul` ports. It computes each tile's activation, weight and output addresses incrementally, waits for the core's response to each tile, and returns one response with the tile count.

## Interface
- `SYSTOLIC_ARRAY_DIM`, default 8: tile edge in elements.
- `DATA_WIDTH_BITS`, default 16: element width; must be a multiple of 8.
- `clock`  in  1: the single clock.
- `areset`  in  1: reset, synchronous and active-high.
- `cmd_gemm_valid` / `cmd_gemm_ready`  in / out  1: GEMM command handshake.
- `cmd_gemm_m_tiles`  in  16: number of activation tile rows.
- `cmd_gemm_n_tiles`  in  16: number of weight tile columns.
- `cmd_gemm_inner_dimension`  in  20: K, in elements.
- `cmd_gemm_act_addr`, `cmd_gemm_wgt_addr`, `cmd_gemm_out_addr`  in  64 each: base byte addresses.
- `resp_gemm_valid` / `resp_gemm_ready`  out / in  1: completion handshake.
- `resp_gemm_tiles_done`  out  32: number of tiles issued and completed.
- `mm_cmd_valid` / `mm_cmd_ready`  out / in  1: per-tile command to the core.
- `mm_cmd_inner_dimension`  out  20: K for the tile.
- `mm_cmd_act_addr`, `mm_cmd_wgt_addr`, `mm_cmd_out_addr`  out  64 each: tile addresses.
- `mm_resp_valid` / `mm_resp_ready`  in / out  1: per-tile completion from the core.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Derived constants:
  - BYTES = DATA_WIDTH_BITS/8.
  - OUT_TILE_BYTES = DIM·DIM·BYTES.
- Stride latched at accept:
  - K_STRIDE = K·DIM·BYTES, 64-bit.
  - Multiplication is by constants only.
- Loop order: row i is the outer loop (0..m-1), column j the inner loop (0..n-1).
- Address of tile (i, j):
  - act = act_base + i·K_STRIDE
  - wgt = wgt_base + j·K_STRIDE
  - out = out_base + (i·n + j)·OUT_TILE_BYTES
- Addresses are produced by running adders, never by multipliers:
  - out advances by OUT_TILE_BYTES every tile.
  - wgt advances by K_STRIDE per tile and reloads wgt_base on j wrap.
  - act advances by K_STRIDE on j wrap.
  - All address arithmetic is modulo 2^64.
- FSM states:
  - IDLE: `cmd_gemm_ready`=1. On fire, latch the command. If m=0, n=0 or K=0, go to RESP with count 0; otherwise go to ISSUE.
  - ISSUE: `mm_cmd_valid`=1. On `mm_cmd_ready`, go to WAIT.
  - WAIT: `mm_resp_ready`=1. On `mm_resp_valid`, increment the count. If (i, j) is the last tile, go to RESP; otherwise advance the indices and addresses and go to ISSUE.
  - RESP: `resp_gemm_valid`=1. On `resp_gemm_ready`, go to IDLE.
- At most one tile is outstanding at the core.
- `mm_cmd_*` fields stay stable while `mm_cmd_valid` is high.
- `resp_gemm_tiles_done` stays stable while `resp_gemm_valid` is high.
- If `mm_resp_valid` arrives outside WAIT, it is not acknowledged.
- Reset values:
  - State IDLE; all valid outputs 0; `busy` 0.
  - `cmd_gemm_ready` 1; `mm_resp_ready` 0.
  - Counters and addresses 0; `resp_gemm_tiles_done` 0.
- Reset during any state returns to IDLE on the next edge. The in-flight tile is abandoned; the core shares this reset.

## Timing
- Command accepted at edge t: `mm_cmd_valid` is high in cycle t+1.
- Each tile costs 1 cycle in ISSUE plus 1 cycle in WAIT when the core is immediately ready and responds immediately.
- `mm_resp` fire at edge t: the next `mm_cmd_valid`, or `resp_gemm_valid` for the last tile, is high in cycle t+1.
- Zero-size command: `resp_gemm_valid` is high in cycle t+1 with `resp_gemm_tiles_done` = 0. The core sees no command.
- Ready signals depend only on state, with no combinational path from inputs.
- A new `cmd_gemm` can be accepted the cycle after the `resp_gemm` fire.

## Structure
- Package `systolic_sched_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - constant functions for BYTES and OUT_TILE_BYTES;
  - the address width (64) and K width (20).
- Sub-module `tile_addr_gen` holds the i/j counters, the three running address registers and the last-tile flag. It has `load` and `advance` inputs.
- The FSM and handshakes stay in the top module.

## Test plan
Parameters for all scenarios: DIM=8, DATA=16, so BYTES=2, OUT_TILE_BYTES=0x80. With K=4, K_STRIDE=0x40.
- **Basic 2×3 GEMM.** Inputs: m=2, n=3, K=4, act=0x1000, wgt=0x2000, out=0x3000; core always ready and responds next cycle.
  - Expect exactly 6 `mm_cmd` fires.
  - act sequence: 0x1000 ×3, then 0x1040 ×3.
  - wgt sequence: 0x2000, 0x2040, 0x2080, then repeated.
  - out sequence: 0x3000 to 0x3280 in steps of 0x80.
  - Then `resp_gemm` with tiles_done=6.
- **Zero-size commands.** m=0, n=5; then m=3, K=0.
  - No `mm_cmd_valid` for either command.
  - Each returns `resp_gemm_valid` the next cycle with tiles_done=0.
- **Backpressure.** m=1, n=2; hold `mm_cmd_ready` low for 5 cycles, then `resp_gemm_ready` low for 4 cycles.
  - `mm_cmd` fields stable throughout.
  - Only 2 fires.
  - resp held stable until accepted.
- **Address wrap.** wgt=0xFFFF_FFFF_FFFF_FFC0, n=2, K=4.
  - Second wgt address is 0x0.
- **Reset mid-WAIT.** Assert `areset` one cycle during tile 2 of a 2×2 GEMM.
  - Outputs return to reset values.
  - A following 1×1 GEMM completes with tiles_done=1.
- **Spurious core response.** `mm_resp_valid` pulsed in IDLE and ISSUE.
  - `mm_resp_ready` stays 0.
  - Count unaffected.

Source files
------------

// File: rtl/systolic_sched_pkg.sv
// Shared types and constants for the systolic GEMM scheduler.
// Address/K widths, FSM states and byte-size helpers.
package systolic_sched_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned K_W    = 20;
    localparam int unsigned TILE_W = 16;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    function automatic int unsigned elem_bytes(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned out_tile_bytes(
        input int unsigned dim,
        input int unsigned dw
    );
        return dim * dim * elem_bytes(dw);
    endfunction

endpackage

// File: rtl/systolic_gemm_scheduler_if.sv
// Host-side GEMM command/response bundle and core-side per-tile
// matmul command/response bundle.
interface gemm_host_if;
    import systolic_sched_pkg::*;

    logic              cmd_gemm_valid;
    logic              cmd_gemm_ready;
    logic [TILE_W-1:0] cmd_gemm_m_tiles;
    logic [TILE_W-1:0] cmd_gemm_n_tiles;
    logic [K_W-1:0]    cmd_gemm_inner_dimension;
    logic [ADDR_W-1:0] cmd_gemm_act_addr;
    logic [ADDR_W-1:0] cmd_gemm_wgt_addr;
    logic [ADDR_W-1:0] cmd_gemm_out_addr;
    logic              resp_gemm_valid;
    logic              resp_gemm_ready;
    logic [CNT_W-1:0]  resp_gemm_tiles_done;

    modport master (
        output cmd_gemm_valid,
        output cmd_gemm_m_tiles,
        output cmd_gemm_n_tiles,
        output cmd_gemm_inner_dimension,
        output cmd_gemm_act_addr,
        output cmd_gemm_wgt_addr,
        output cmd_gemm_out_addr,
        output resp_gemm_ready,
        input  cmd_gemm_ready,
        input  resp_gemm_valid,
        input  resp_gemm_tiles_done
    );

    modport slave (
        input  cmd_gemm_valid,
        input  cmd_gemm_m_tiles,
        input  cmd_gemm_n_tiles,
        input  cmd_gemm_inner_dimension,
        input  cmd_gemm_act_addr,
        input  cmd_gemm_wgt_addr,
        input  cmd_gemm_out_addr,
        input  resp_gemm_ready,
        output cmd_gemm_ready,
        output resp_gemm_valid,
        output resp_gemm_tiles_done
    );

endinterface

interface gemm_core_if;
    import systolic_sched_pkg::*;

    logic              mm_cmd_valid;
    logic              mm_cmd_ready;
    logic [K_W-1:0]    mm_cmd_inner_dimension;
    logic [ADDR_W-1:0] mm_cmd_act_addr;
    logic [ADDR_W-1:0] mm_cmd_wgt_addr;
    logic [ADDR_W-1:0] mm_cmd_out_addr;
    logic              mm_resp_valid;
    logic              mm_resp_ready;

    modport master (
        output mm_cmd_valid,
        output mm_cmd_inner_dimension,
        output mm_cmd_act_addr,
        output mm_cmd_wgt_addr,
        output mm_cmd_out_addr,
        output mm_resp_ready,
        input  mm_cmd_ready,
        input  mm_resp_valid
    );

    modport slave (
        input  mm_cmd_valid,
        input  mm_cmd_inner_dimension,
        input  mm_cmd_act_addr,
        input  mm_cmd_wgt_addr,
        input  mm_cmd_out_addr,
        input  mm_resp_ready,
        output mm_cmd_ready,
        output mm_resp_valid
    );

endinterface

// File: rtl/systolic_gemm_scheduler_tile_addr_gen.sv
// Tile index counters and running act/wgt/out address registers.
// Addresses advance by adders only; all arithmetic wraps at 2^64.
module tile_addr_gen
    import systolic_sched_pkg::*;
#(
    parameter int unsigned DIM = 8,
    parameter int unsigned DW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [TILE_W-1:0] m_i,
    input  logic [TILE_W-1:0] n_i,
    input  logic [K_W-1:0]    k_i,
    input  logic [ADDR_W-1:0] act_base_i,
    input  logic [ADDR_W-1:0] wgt_base_i,
    input  logic [ADDR_W-1:0] out_base_i,
    output logic [ADDR_W-1:0] act_o,
    output logic [ADDR_W-1:0] wgt_o,
    output logic [ADDR_W-1:0] out_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ROW_B =
        ADDR_W'(DIM * elem_bytes(DW));
    localparam logic [ADDR_W-1:0] OUT_TB =
        ADDR_W'(out_tile_bytes(DIM, DW));

    logic [TILE_W-1:0] m_q, m_d;
    logic [TILE_W-1:0] n_q, n_d;
    logic [TILE_W-1:0] i_q, i_d;
    logic [TILE_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] kstr_q, kstr_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;
    logic [ADDR_W-1:0] act_q, act_d;
    logic [ADDR_W-1:0] wgt_q, wgt_d;
    logic [ADDR_W-1:0] out_q, out_d;
    logic              j_last;
    logic              i_last;

    assign j_last = (j_q == n_q - TILE_W'(1));
    assign i_last = (i_q == m_q - TILE_W'(1));
    assign last_o = i_last && j_last;
    assign act_o  = act_q;
    assign wgt_o  = wgt_q;
    assign out_o  = out_q;

    always_comb begin
        m_d     = m_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        kstr_d  = kstr_q;
        wbase_d = wbase_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        out_d   = out_q;
        if (load_i) begin
            m_d     = m_i;
            n_d     = n_i;
            i_d     = '0;
            j_d     = '0;
            kstr_d  = {{(ADDR_W-K_W){1'b0}}, k_i} * ROW_B;
            wbase_d = wgt_base_i;
            act_d   = act_base_i;
            wgt_d   = wgt_base_i;
            out_d   = out_base_i;
        end else if (advance_i) begin
            out_d = out_q + OUT_TB;
            // Column wrap: next activation row, weights restart.
            if (j_last) begin
                j_d   = '0;
                i_d   = i_q + TILE_W'(1);
                act_d = act_q + kstr_q;
                wgt_d = wbase_q;
            end else begin
                j_d   = j_q + TILE_W'(1);
                wgt_d = wgt_q + kstr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            kstr_q  <= '0;
            wbase_q <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            out_q   <= '0;
        end else begin
            m_q     <= m_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kstr_q  <= kstr_d;
            wbase_q <= wbase_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: rtl/systolic_gemm_scheduler.sv
// Splits one GEMM command into single-tile matmul commands,
// one outstanding at a time, and reports the completed tile count.
module systolic_gemm_scheduler
    import systolic_sched_pkg::*;
#(
    parameter int unsigned SYSTOLIC_ARRAY_DIM = 8,
    parameter int unsigned DATA_WIDTH_BITS    = 16
) (
    input  logic        clock,
    input  logic        areset,
    gemm_host_if.slave  host,
    gemm_core_if.master core,
    output logic        busy
);

    state_e           state_q;
    logic             cmd_rdy_q;
    logic             mm_vld_q;
    logic             mm_rrdy_q;
    logic             resp_vld_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [K_W-1:0]   k_q;

    logic             load;
    logic             advance;
    logic             last;
    logic             zero_cmd;
    logic             resp_fire;

    assign zero_cmd  = (host.cmd_gemm_m_tiles == '0)
                    || (host.cmd_gemm_n_tiles == '0)
                    || (host.cmd_gemm_inner_dimension == '0);
    assign load      = cmd_rdy_q && host.cmd_gemm_valid;
    assign resp_fire = mm_rrdy_q && core.mm_resp_valid;
    assign advance   = resp_fire && !last;

    tile_addr_gen #(
        .DIM (SYSTOLIC_ARRAY_DIM),
        .DW  (DATA_WIDTH_BITS)
    ) u_addr (
        .clk        (clock),
        .rst        (areset),
        .load_i     (load),
        .advance_i  (advance),
        .m_i        (host.cmd_gemm_m_tiles),
        .n_i        (host.cmd_gemm_n_tiles),
        .k_i        (host.cmd_gemm_inner_dimension),
        .act_base_i (host.cmd_gemm_act_addr),
        .wgt_base_i (host.cmd_gemm_wgt_addr),
        .out_base_i (host.cmd_gemm_out_addr),
        .act_o      (core.mm_cmd_act_addr),
        .wgt_o      (core.mm_cmd_wgt_addr),
        .out_o      (core.mm_cmd_out_addr),
        .last_o     (last)
    );

    assign host.cmd_gemm_ready       = cmd_rdy_q;
    assign host.resp_gemm_valid      = resp_vld_q;
    assign host.resp_gemm_tiles_done = cnt_q;
    assign core.mm_cmd_valid         = mm_vld_q;
    assign core.mm_cmd_inner_dimension = k_q;
    assign core.mm_resp_ready        = mm_rrdy_q;
    assign busy                      = busy_q;

    // All handshake outputs are registered and change only with state.
    always_ff @(posedge clock) begin
        if (areset) begin
            state_q    <= IDLE;
            cmd_rdy_q  <= 1'b1;
            mm_vld_q   <= 1'b0;
            mm_rrdy_q  <= 1'b0;
            resp_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            k_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (host.cmd_gemm_valid) begin
                        k_q       <= host.cmd_gemm_inner_dimension;
                        cnt_q     <= '0;
                        cmd_rdy_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (zero_cmd) begin
                            state_q    <= RESP;
                            resp_vld_q <= 1'b1;
                        end else begin
                            state_q  <= ISSUE;
                            mm_vld_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (core.mm_cmd_ready) begin
                        state_q   <= WAIT;
                        mm_vld_q  <= 1'b0;
                        mm_rrdy_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (core.mm_resp_valid) begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        mm_rrdy_q <= 1'b0;
                        if (last) begin
                            state_q    <= RESP;
                            resp_vld_q <= 1'b1;
                        end else begin
                            state_q  <= ISSUE;
                            mm_vld_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (host.resp_gemm_ready) begin
                        state_q    <= IDLE;
                        resp_vld_q <= 1'b0;
                        cmd_rdy_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_gemm_scheduler.sv
// Scoreboard bench for systolic_gemm_scheduler (DIM=8, 16-bit data).
module tb_systolic_gemm_scheduler;

    typedef struct packed {
        logic [63:0] act;
        logic [63:0] wgt;
        logic [63:0] out;
        logic [19:0] k;
    } tile_t;

    logic clock = 1'b0;
    logic areset;
    logic busy;

    always #5 clock = ~clock;

    gemm_host_if hif ();
    gemm_core_if cif ();

    systolic_gemm_scheduler #(
        .SYSTOLIC_ARRAY_DIM (8),
        .DATA_WIDTH_BITS    (16)
    ) dut (
        .clock  (clock),
        .areset (areset),
        .host   (hif),
        .core   (cif),
        .busy   (busy)
    );

    tile_t       tileq[$];
    int unsigned respq[$];
    int          checks = 0;
    int          errors = 0;
    int          cmd_fires = 0;
    int          tiles_left = 0;
    bit          owe = 0;
    bit          resp_seen = 0;
    bit          host_seen = 0;
    bit          hold_cmd = 0;
    bit          hold_resp = 0;
    tile_t       hold_t;
    logic [31:0] hold_done;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic tile_t cur_tile();
        tile_t t;
        t.act = cif.mm_cmd_act_addr;
        t.wgt = cif.mm_cmd_wgt_addr;
        t.out = cif.mm_cmd_out_addr;
        t.k   = cif.mm_cmd_inner_dimension;
        return t;
    endfunction

    // One clock: evaluate handshakes due at the coming edge, then
    // advance to the next falling edge and play the core model.
    task automatic step();
        bit    cf, rf, hf, gf;
        tile_t cur, now, e;
        cf  = cif.mm_cmd_valid && cif.mm_cmd_ready;
        rf  = cif.mm_resp_valid && cif.mm_resp_ready;
        hf  = hif.cmd_gemm_valid && hif.cmd_gemm_ready;
        gf  = hif.resp_gemm_valid && hif.resp_gemm_ready;
        cur = cur_tile();
        hold_cmd  = cif.mm_cmd_valid && !cf && !areset;
        hold_t    = cur;
        hold_resp = hif.resp_gemm_valid && !gf && !areset;
        hold_done = hif.resp_gemm_tiles_done;
        if (cf) begin
            cmd_fires++;
            if (tileq.size() == 0) begin
                check_eq("unexpected_mm_cmd", 1, 0);
            end else begin
                e = tileq.pop_front();
                check_eq("mm_act", cur.act, e.act);
                check_eq("mm_wgt", cur.wgt, e.wgt);
                check_eq("mm_out", cur.out, e.out);
                check_eq("mm_k", 64'(cur.k), 64'(e.k));
            end
        end
        if (gf) begin
            resp_seen = 1;
            if (respq.size() == 0)
                check_eq("unexpected_resp", 1, 0);
            else
                check_eq("tiles_done", 64'(hif.resp_gemm_tiles_done),
                         64'(respq.pop_front()));
            check_eq("tiles_drained", 64'(tileq.size()), 0);
        end
        if (hf) host_seen = 1;
        @(negedge clock);
        if (hold_cmd) begin
            now = cur_tile();
            check_eq("cmd_hold_valid", 64'(cif.mm_cmd_valid), 1);
            check_eq("cmd_hold_act", now.act, hold_t.act);
            check_eq("cmd_hold_wgt", now.wgt, hold_t.wgt);
            check_eq("cmd_hold_out", now.out, hold_t.out);
        end
        if (hold_resp) begin
            check_eq("resp_hold_valid", 64'(hif.resp_gemm_valid), 1);
            check_eq("resp_hold_done", 64'(hif.resp_gemm_tiles_done),
                     64'(hold_done));
        end
        if (rf && tiles_left > 0) begin
            owe = 0;
            tiles_left--;
            if (tiles_left == 0)
                check_eq("lat_resp", 64'(hif.resp_gemm_valid), 1);
            else
                check_eq("lat_next_cmd", 64'(cif.mm_cmd_valid), 1);
        end
        if (cf) owe = 1;
        cif.mm_resp_valid = owe;
    endtask

    task automatic send_gemm(input int m, input int n, input int k,
                             input logic [63:0] a, input logic [63:0] w,
                             input logic [63:0] o);
        logic [63:0] ks;
        tile_t       t;
        bit          zero;
        int          cnt;
        zero = (m == 0) || (n == 0) || (k == 0);
        ks   = 64'(k) * 64'd16;
        if (!zero) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    t.act = a + 64'(i) * ks;
                    t.wgt = w + 64'(j) * ks;
                    t.out = o + 64'(i * n + j) * 64'h80;
                    t.k   = 20'(k);
                    tileq.push_back(t);
                end
            end
        end
        respq.push_back(zero ? 0 : m * n);
        tiles_left = zero ? 0 : m * n;
        hif.cmd_gemm_m_tiles         = 16'(m);
        hif.cmd_gemm_n_tiles         = 16'(n);
        hif.cmd_gemm_inner_dimension = 20'(k);
        hif.cmd_gemm_act_addr        = a;
        hif.cmd_gemm_wgt_addr        = w;
        hif.cmd_gemm_out_addr        = o;
        hif.cmd_gemm_valid           = 1'b1;
        host_seen = 0;
        cnt = 0;
        while (!host_seen && cnt < 20) begin
            step();
            cnt++;
        end
        hif.cmd_gemm_valid = 1'b0;
        if (!host_seen) begin
            check_eq("accept_timeout", 0, 1);
        end else if (zero) begin
            check_eq("zero_resp_lat", 64'(hif.resp_gemm_valid), 1);
            check_eq("zero_no_cmd", 64'(cif.mm_cmd_valid), 0);
            check_eq("zero_busy", 64'(busy), 1);
        end else begin
            check_eq("lat_first_cmd", 64'(cif.mm_cmd_valid), 1);
            check_eq("issue_busy", 64'(busy), 1);
        end
    endtask

    task automatic run_until_resp(input int budget);
        int cnt;
        cnt = 0;
        resp_seen = 0;
        while (!resp_seen && cnt < budget) begin
            step();
            cnt++;
        end
        if (!resp_seen) check_eq("resp_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_cmd_ready"}, 64'(hif.cmd_gemm_ready), 1);
        check_eq({tag, "_mm_valid"}, 64'(cif.mm_cmd_valid), 0);
        check_eq({tag, "_mm_rready"}, 64'(cif.mm_resp_ready), 0);
        check_eq({tag, "_resp_valid"}, 64'(hif.resp_gemm_valid), 0);
        check_eq({tag, "_busy"}, 64'(busy), 0);
        check_eq({tag, "_done"}, 64'(hif.resp_gemm_tiles_done), 0);
        check_eq({tag, "_act"}, cif.mm_cmd_act_addr, 0);
        check_eq({tag, "_out"}, cif.mm_cmd_out_addr, 0);
    endtask

    initial begin
        int f0;
        int cnt;
        areset = 1'b1;
        hif.cmd_gemm_valid           = 1'b0;
        hif.cmd_gemm_m_tiles         = '0;
        hif.cmd_gemm_n_tiles         = '0;
        hif.cmd_gemm_inner_dimension = '0;
        hif.cmd_gemm_act_addr        = '0;
        hif.cmd_gemm_wgt_addr        = '0;
        hif.cmd_gemm_out_addr        = '0;
        hif.resp_gemm_ready          = 1'b1;
        cif.mm_cmd_ready             = 1'b1;
        cif.mm_resp_valid            = 1'b0;
        repeat (3) step();
        areset = 1'b0;
        check_reset_vals("reset");

        // Basic 2x3 GEMM
        f0 = cmd_fires;
        send_gemm(2, 3, 4, 64'h1000, 64'h2000, 64'h3000);
        run_until_resp(100);
        check_eq("basic_fires", 64'(cmd_fires - f0), 6);

        // Zero-size commands
        f0 = cmd_fires;
        send_gemm(0, 5, 4, 64'h1000, 64'h2000, 64'h3000);
        run_until_resp(10);
        send_gemm(3, 2, 0, 64'h1000, 64'h2000, 64'h3000);
        run_until_resp(10);
        check_eq("zero_fires", 64'(cmd_fires - f0), 0);

        // Backpressure on mm_cmd and resp_gemm
        f0 = cmd_fires;
        cif.mm_cmd_ready = 1'b0;
        send_gemm(1, 2, 4, 64'h4000, 64'h5000, 64'h6000);
        repeat (5) step();
        check_eq("bp_stalled", 64'(cmd_fires - f0), 0);
        cif.mm_cmd_ready = 1'b1;
        hif.resp_gemm_ready = 1'b0;
        cnt = 0;
        while (!hif.resp_gemm_valid && cnt < 50) begin
            step();
            cnt++;
        end
        check_eq("bp_resp_valid", 64'(hif.resp_gemm_valid), 1);
        repeat (4) step();
        hif.resp_gemm_ready = 1'b1;
        run_until_resp(5);
        check_eq("bp_fires", 64'(cmd_fires - f0), 2);

        // Weight address wrap at 2^64
        send_gemm(1, 2, 4, 64'h7000, 64'hFFFF_FFFF_FFFF_FFC0, 64'h8000);
        run_until_resp(20);

        // Reset while waiting on tile 2 of a 2x2 GEMM
        f0 = cmd_fires;
        send_gemm(2, 2, 4, 64'h9000, 64'hA000, 64'hB000);
        cnt = 0;
        while (cmd_fires - f0 < 2 && cnt < 50) begin
            step();
            cnt++;
        end
        check_eq("rst_in_wait", 64'(cif.mm_resp_ready), 1);
        areset = 1'b1;
        cif.mm_resp_valid = 1'b0;
        owe = 0;
        step();
        areset = 1'b0;
        tileq.delete();
        respq.delete();
        tiles_left = 0;
        check_reset_vals("midrst");
        send_gemm(1, 1, 4, 64'hC000, 64'hD000, 64'hE000);
        run_until_resp(20);

        // Spurious core responses in IDLE and ISSUE
        cif.mm_resp_valid = 1'b1;
        step();
        check_eq("spur_idle_rdy", 64'(cif.mm_resp_ready), 0);
        check_eq("spur_idle_busy", 64'(busy), 0);
        cif.mm_cmd_ready = 1'b0;
        send_gemm(1, 2, 4, 64'h1_0000, 64'h2_0000, 64'h3_0000);
        for (int r = 0; r < 2; r++) begin
            cif.mm_resp_valid = 1'b1;
            step();
            check_eq("spur_issue_rdy", 64'(cif.mm_resp_ready), 0);
            check_eq("spur_issue_vld", 64'(cif.mm_cmd_valid), 1);
        end
        cif.mm_cmd_ready = 1'b1;
        run_until_resp(20);

        check_eq("queues_empty", 64'(tileq.size() + respq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
